// File: rtl/wbus_transfer_sequencer.sv
// WBUS scheduler: queues register-to-register move commands and sequences
// each one as a SETUP (source drives) cycle followed by an XFER (destination loads) cycle.
module wbus_transfer_sequencer #(
  parameter int N_PORTS = 8,
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 4,
  localparam int LVL_W  = (SEL_W > $clog2(DEPTH + 1)) ? SEL_W : $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               nCLR,
  input  logic               req,
  input  logic [SEL_W-1:0]   src,
  input  logic [SEL_W-1:0]   dst,
  output logic               ready,
  input  logic               halt,
  output logic [N_PORTS-1:0] E,
  output logic [N_PORTS-1:0] nL,
  output logic               done,
  output logic               err,
  output logic [LVL_W-1:0]   level,
  output logic               busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0]   FULL = LVL_W'(DEPTH);
  localparam logic [SEL_W:0]     NP   = (SEL_W + 1)'(N_PORTS);
  localparam logic [N_PORTS-1:0] ONE  = N_PORTS'(1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

  state_t             state, state_next;
  logic [2*SEL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   count;
  logic [SEL_W-1:0]   cur_src, cur_dst;
  logic               cmd_ok, push, pop, err_r;

  assign cmd_ok = (src != dst) && ({1'b0, src} < NP) && ({1'b0, dst} < NP);
  assign ready  = (count != FULL);
  assign push   = req && ready && cmd_ok;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !halt) begin
          state_next = SETUP;
          pop        = 1'b1;
        end
      end
      SETUP: state_next = XFER;
      XFER: begin
        if ((count != '0) && !halt) begin
          state_next = SETUP;
          pop        = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control: FSM, FIFO pointers/occupancy and the reject pulse
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_r  <= 1'b0;
    end else begin
      state <= state_next;
      err_r <= req && ready && !cmd_ok;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data: FIFO storage and the current command; meaningful only while state != IDLE
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {src, dst};
    if (pop)  {cur_src, cur_dst} <= mem[rd_ptr];
  end

  assign E     = (state != IDLE) ? (ONE << cur_src) : '0;
  assign nL    = (state == XFER) ? ~(ONE << cur_dst) : '1;
  assign done  = (state == XFER);
  assign err   = err_r;
  assign level = count;
  assign busy  = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_wbus_transfer_sequencer.sv
// Directed bench for wbus_transfer_sequencer: expected transfers are queued at push
// time and a negedge monitor checks each XFER against the queue head.
module tb_wbus_transfer_sequencer;
  logic       CLK = 1'b0, nCLR = 1'b0, req = 1'b0, halt = 1'b0;
  logic [2:0] src = '0, dst = '0;
  logic       ready, done, err, busy;
  logic [7:0] E, nL;
  logic [2:0] level;

  logic       req6 = 1'b0;
  logic [2:0] src6 = '0, dst6 = '0;
  logic       ready6, done6, err6, busy6;
  logic [5:0] E6, nL6;
  logic [2:0] level6;

  int         total = 0, bad = 0;
  logic [5:0] exp_q [$];
  logic [5:0] head;
  logic [7:0] want_e, want_nl;
  logic [7:0] regs [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [7:0] r6;
  logic [5:0] pat;

  wbus_transfer_sequencer dut (
    .CLK(CLK), .nCLR(nCLR), .req(req), .src(src), .dst(dst), .ready(ready),
    .halt(halt), .E(E), .nL(nL), .done(done), .err(err), .level(level), .busy(busy)
  );

  wbus_transfer_sequencer #(.N_PORTS(6)) dut6 (
    .CLK(CLK), .nCLR(nCLR), .req(req6), .src(src6), .dst(dst6), .ready(ready6),
    .halt(1'b1), .E(E6), .nL(nL6), .done(done6), .err(err6), .level(level6), .busy(busy6)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] s, input logic [2:0] d);
    logic acc;
    acc = 1'b0;
    req = 1'b1; src = s; dst = d;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = ready;
      step();
    end
    req = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL push_timeout: src=%0d dst=%0d never accepted", s, d);
    end else if (s != d) begin
      exp_q.push_back({s, d});
    end
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      if (!busy) idle = 1'b1;
      else step();
    end
    if (!idle) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b level=%0d", busy, level);
    end
  endtask

  // WBUS and bus-register model: destination latches on the negedge
  always @(negedge CLK) begin
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) if (E[i]) w = w | regs[i];
    for (int i = 0; i < 8; i++) if (!nL[i]) regs[i] <= w;
  end

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (nCLR) begin
      chk("e_onehot0", 32'($onehot0(E)), 32'd1);
      chk("nl_onecold", 32'($onehot0(~nL)), 32'd1);
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: E=%b nL=%b want no transfer", E, nL);
        end else begin
          head    = exp_q.pop_front();
          want_e  = 8'b1 << head[5:3];
          want_nl = ~(8'b1 << head[2:0]);
          chk("xfer_E", 32'(E), 32'(want_e));
          chk("xfer_nL", 32'(nL), 32'(want_nl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    nCLR = 1'b0;
    step(); step();
    chk("rst_E", 32'(E), 32'h00);
    chk("rst_nL", 32'(nL), 32'hff);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    nCLR = 1'b1;
    step();

    // Single move 2 -> 5 with exact latency
    push_cmd(3'd2, 3'd5);
    step();
    chk("t1_setup_E", 32'(E), 32'h04);
    chk("t1_setup_nL", 32'(nL), 32'hff);
    step();
    chk("t1_xfer_E", 32'(E), 32'h04);
    chk("t1_xfer_nL", 32'(nL), 32'hdf);
    chk("t1_done", 32'(done), 32'd1);
    step();
    chk("t1_idle_E", 32'(E), 32'h00);
    chk("t1_idle_nL", 32'(nL), 32'hff);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_reg5", 32'(regs[5]), 32'h12);

    // Back-to-back: done every other cycle, no IDLE gap
    push_cmd(3'd1, 3'd3);
    push_cmd(3'd4, 3'd0);
    push_cmd(3'd6, 3'd7);
    pat = {5'b0, done};
    for (int i = 0; i < 5; i++) begin
      step();
      pat = {pat[4:0], done};
    end
    chk("b2b_done_pattern", 32'(pat), 32'h2a);
    chk("b2b_busy", 32'(busy), 32'd0);

    // Fill under halt, ignored 5th request, drain, then wrap pointers
    halt = 1'b1;
    push_cmd(3'd0, 3'd1);
    push_cmd(3'd2, 3'd3);
    push_cmd(3'd4, 3'd5);
    push_cmd(3'd6, 3'd7);
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(ready), 32'd0);
    req = 1'b1; src = 3'd1; dst = 3'd2;
    step();
    req = 1'b0;
    chk("full_ignored_level", 32'(level), 32'd4);
    chk("full_ignored_err", 32'(err), 32'd0);
    halt = 1'b0;
    wait_idle();
    push_cmd(3'd7, 3'd6);
    push_cmd(3'd5, 3'd4);
    push_cmd(3'd3, 3'd2);
    push_cmd(3'd1, 3'd0);
    push_cmd(3'd0, 3'd7);
    push_cmd(3'd2, 3'd6);
    wait_idle();

    // Reject src == dst, and out-of-range codes on the 6-port instance
    push_cmd(3'd3, 3'd3);
    chk("rej_err", 32'(err), 32'd1);
    chk("rej_level", 32'(level), 32'd0);
    chk("rej_E", 32'(E), 32'h00);
    step();
    chk("rej_err_pulse", 32'(err), 32'd0);
    req6 = 1'b1; src6 = 3'd7; dst6 = 3'd1;
    step();
    chk("rej6_src_err", 32'(err6), 32'd1);
    src6 = 3'd1; dst6 = 3'd6;
    step();
    chk("rej6_dst_err", 32'(err6), 32'd1);
    src6 = 3'd1; dst6 = 3'd2;
    step();
    req6 = 1'b0;
    chk("ok6_err", 32'(err6), 32'd0);
    chk("ok6_level", 32'(level6), 32'd1);

    // Halt raised during SETUP: transfer completes, next one waits
    push_cmd(3'd0, 3'd1);
    push_cmd(3'd2, 3'd3);
    chk("halt_setup_E", 32'(E), 32'h01);
    halt = 1'b1;
    step();
    chk("halt_xfer_done", 32'(done), 32'd1);
    chk("halt_xfer_nL", 32'(nL), 32'hfd);
    step();
    chk("halt_idle_E", 32'(E), 32'h00);
    chk("halt_level", 32'(level), 32'd1);
    chk("halt_busy", 32'(busy), 32'd1);
    step();
    chk("halt_hold_level", 32'(level), 32'd1);
    halt = 1'b0;
    step();
    chk("halt_resume_E", 32'(E), 32'h04);
    wait_idle();

    // Reset in the XFER cycle before the load edge
    r6 = regs[6];
    push_cmd(3'd5, 3'd6);
    step();
    step();
    chk("rx_pre_done", 32'(done), 32'd1);
    nCLR = 1'b0;
    #1;
    exp_q.delete();
    chk("rx_E", 32'(E), 32'h00);
    chk("rx_nL", 32'(nL), 32'hff);
    chk("rx_done", 32'(done), 32'd0);
    chk("rx_level", 32'(level), 32'd0);
    @(negedge CLK);
    #1;
    chk("rx_reg6_kept", 32'(regs[6]), 32'(r6));
    step();
    nCLR = 1'b1;
    step();
    chk("rx_post_level", 32'(level), 32'd0);
    chk("rx_post_ready", 32'(ready), 32'd1);
    chk("rx_post_busy", 32'(busy), 32'd0);

    chk("all_transfers_seen", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wbus_transfer_sequencer.md
Name: wbus_transfer_sequencer

Overview:
Central WBUS scheduler for the SAP-II datapath. It accepts register-to-register move commands (source, destination) through a valid/ready handshake and queues them in a small FIFO. It then drives the per-register bus enables (Ex) and active-low loads (nLx), so that exactly one source drives WBUS while exactly one destination latches it. Only this block drives the Ex/nLx lines for registers on the bus, e.g. TMP: Et/nLt.

Parameters:
N_PORTS, 8, number of bus-attached registers; src/dst codes are 0..N_PORTS-1
SEL_W, 3, width of src/dst codes (clog2 of N_PORTS)
DEPTH, 4, command FIFO depth (power of two)

Ports:
CLK  input  1  system clock; this block updates on posedge, bus registers load on negedge
nCLR  input  1  asynchronous active-low reset
req  input  1  command valid
src  input  SEL_W  source register code
dst  input  SEL_W  destination register code
ready  output  1  FIFO can accept a command (not full)
halt  input  1  stop issuing new transfers; an in-flight transfer completes
E  output  N_PORTS  one-hot-or-zero bus enables, one per register (active-high)
nL  output  N_PORTS  one-cold-or-all-ones loads, one per register (active-low)
done  output  1  one-cycle pulse during the XFER cycle of each transfer
err  output  1  one-cycle pulse when a command is rejected
level  output  SEL_W  number of queued commands, 0..DEPTH; width is max(SEL_W, clog2(DEPTH+1))
busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty

Behaviour:
- Reset (nCLR=0, asynchronous): E=0, nL=all ones, done=0, err=0, level=0, busy=0, ready=1, FIFO cleared, FSM=IDLE. The bus is released immediately, including mid-transfer. Any aborted transfer is lost, and its destination does not load.
- Accept: on posedge, if req=1 and ready=1 and src!=dst and src<N_PORTS and dst<N_PORTS, the command is written to the FIFO.
- Reject: if req=1 and (src==dst or either code is out of range), the command is not queued and err=1 for the following cycle. A req while ready=0 is ignored silently, with no err; the requester must hold req.
- ready = (level != DEPTH). A push in the same cycle as a pop while full is refused; ready depends only on the registered level.
- FSM states: IDLE, SETUP, XFER. All transitions occur on posedge.
  - IDLE -> SETUP: FIFO non-empty and halt=0. Pop the head into the registered cur_src/cur_dst.
  - SETUP: E[cur_src]=1, nL all ones. This is one cycle of bus settling.
  - SETUP -> XFER: unconditional. In XFER, E[cur_src]=1, nL[cur_dst]=0, done=1. The destination latches WBUS on the negedge inside this cycle.
  - XFER -> SETUP: FIFO non-empty and halt=0. Pop the next command (back-to-back).
  - XFER -> IDLE: otherwise.
- halt does not abort SETUP or XFER. It only blocks the next pop.
- Latency: a command pushed at posedge t into an empty FIFO with the FSM IDLE has SETUP in cycle t+1, XFER (done) in cycle t+2, and the FSM back in IDLE at t+3. Sustained throughput is one transfer per 2 cycles.
- A push and a pop in the same cycle are both honoured when not full; level is unchanged.
- FIFO pointers wrap modulo DEPTH. Commands are issued strictly in FIFO order.
- E and nL are decoded from registered state only. They never glitch, and at most one E bit and at most one nL bit are active in any cycle.

Test Plan:
- Reset then single move: push (src=2, dst=5) -> cycle+1 E=0000_0100, nL=FF; cycle+2 E=0000_0100, nL=1101_1111, done=1; cycle+3 E=0, nL=FF, busy=0. A model register on port 5 holds the value driven by port 2.
- Back-to-back: push (1,3), (4,0), (6,7) on consecutive cycles -> three SETUP/XFER pairs with no IDLE gap; done pulses 2 cycles apart; issue order is preserved.
- Full/wrap: with halt=1, push 4 commands -> level=4, ready=0; a 5th req is ignored with no err. Release halt -> all 4 execute in order. Then push 6 more to exercise pointer wrap -> correct order.
- Reject: push (3,3) -> err=1 next cycle, level unchanged, no E/nL activity. Push src=7 with N_PORTS=6 -> err=1.
- Halt mid-transfer: assert halt during SETUP of (0,1) -> XFER still completes (done=1), then IDLE with level held. Deassert halt -> next command starts one cycle later.
- Reset during XFER: pull nCLR low in the XFER cycle before the negedge -> E=0 and nL=FF immediately, destination not loaded, level=0 after release.
